dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Upstream control stage for the DDS test generator. Produces the phase
//  increment, accumulator enable strobe and data-valid flag that drive it.
//  Runs a linear frequency sweep (chirp): every DIV clocks it emits one sample
//  strobe, then steps the phase increment by a programmable amount.
//  Supports single-shot and looped sweeps, with start/stop control.
// PARAMETERS
//  M    24  phase increment / DDS accumulator wordlength, U[M,0]
//  DIV  8   clock cycles per sample strobe; legal range 1..65535
//  NW   16  wordlength of the sweep sample counter
// PORTS
//  clk           in   1   clock
//  ic_rst_n      in   1   asynchronous reset, active low
//  ic_start      in   1   start a sweep; sampled only in IDLE
//  ic_stop       in   1   abort the sweep; priority over everything except reset
//  ic_loop       in   1   1 = restart the sweep at its end; 0 = single shot
//  id_p_start    in   M   first phase increment, U[M,0]
//  id_p_step     in   M   increment added per sample, U[M,0], modulo 2^M
//  id_n_samples  in   NW  samples per sweep, U[NW,0]
//  od_p_ac       out  M   phase increment to DDS, U[M,0]
//  oc_en_ac      out  1   DDS accumulator enable strobe
//  oc_val_data   out  1   data-valid to DDS; identical to oc_en_ac
//  oc_busy       out  1   1 while in RUN
//  oc_done       out  1   one-cycle pulse at the end of a single-shot sweep
// BEHAVIOUR
//  - All outputs are registered. Reset (async, ic_rst_n=0) forces: state IDLE,
//    od_p_ac=0, oc_en_ac=0, oc_val_data=0, oc_busy=0, oc_done=0, counters=0.
//  - FSM has two states, IDLE and RUN.
//  - IDLE -> RUN: on the edge where ic_start=1, ic_stop=0 and id_n_samples!=0.
//    * id_p_start, id_p_step, id_n_samples and ic_loop are latched at that edge.
//    * After that edge: oc_en_ac=1 and od_p_ac=id_p_start (latency 1 clock).
//    * If id_n_samples==0, ic_start is ignored: no strobe, no oc_done.
//  - ic_start is ignored while in RUN. Latched values are frozen during RUN.
//  - Strobe timing in RUN: oc_en_ac is high for 1 cycle, then low for DIV-1
//    cycles. With DIV=1, oc_en_ac stays high continuously.
//  - od_p_ac changes only on the edge that raises oc_en_ac.
//    * Sample k carries p_start + k*p_step, wrapping modulo 2^M.
//    * od_p_ac holds that value for the whole sample period.
//  - End of sweep: the edge that ends the strobe for sample n_samples-1.
//    * loop=1: the next strobe, DIV cycles after the previous one, carries
//      p_start again. The sample counter returns to 0. No oc_done.
//    * loop=0: state goes to IDLE, oc_busy=0 and oc_done=1 for 1 cycle.
//      od_p_ac keeps its last value.
//  - ic_stop=1 at an edge while in RUN:
//    * After that edge: IDLE, oc_en_ac=0, oc_busy=0, oc_done=0.
//    * od_p_ac keeps its value.
//  - ic_start and ic_stop both high in IDLE: stop wins, FSM stays in IDLE.
//  - Reset mid-sweep: all state clears immediately. The next sweep needs a
//    new ic_start.
//  - The divider counter (0..DIV-1) and the sample counter (0..n-1) are cleared
//    on each start. The sample counter is NW bits and never overflows, since
//    n <= 2^NW-1.
// TESTING
//  - Reset: ic_rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately,
//    before the next clk edge.
//  - Single shot (DIV=4, start=0x000100, step=0x000010, n=3, loop=0):
//    * Strobes occur 1, 5 and 9 cycles after the start edge.
//    * od_p_ac = 0x000100, 0x000110, 0x000120.
//    * oc_done pulses at cycle 10 and oc_busy falls at cycle 10.
//  - Loop (same settings, loop=1): the 4th strobe, at cycle 13, carries
//    0x000100 again and oc_done never pulses. Then assert ic_stop ->
//    oc_en_ac and oc_busy low next cycle, od_p_ac held.
//  - Wrap (start=0xFFFFF0, step=0x000020, n=2): od_p_ac = 0xFFFFF0, then
//    0x000010.
//  - Boundaries:
//    * n=0 start -> no strobe and oc_busy stays 0.
//    * start+stop in the same cycle -> stays in IDLE.
//    * ic_start pulses during RUN -> sequence unchanged.
//  - DIV=1, n=4, loop=0: oc_en_ac high for 4 consecutive cycles with
//    increments k*step, then oc_done. Also check oc_val_data == oc_en_ac on
//    every cycle of every test.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//   Control stage in front of the DDS test generator. It runs a linear
//   frequency sweep (chirp). Every DIV clocks it emits one accumulator-enable
//   strobe. Between strobes it steps the phase increment by a programmable
//   amount. Single-shot and looped sweeps are supported, and a sweep can be
//   aborted with ic_stop.
//
// Ports
//   clk           clock
//   ic_rst_n      asynchronous reset, active low
//   ic_start      start a sweep (sampled only while idle)
//   ic_stop       abort; overrides everything except reset
//   ic_loop       1 = restart the sweep at its end, 0 = single shot
//   id_p_start    first phase increment, U[M,0]
//   id_p_step     increment added per sample, modulo 2^M
//   id_n_samples  samples per sweep (0 = start is ignored)
//   od_p_ac       phase increment to the DDS
//   oc_en_ac      DDS accumulator enable strobe
//   oc_val_data   data-valid to the DDS, same register as oc_en_ac
//   oc_busy       high while a sweep is running
//   oc_done       one-cycle pulse at the end of a single-shot sweep
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int M   = 24,
    parameter int DIV = 8,
    parameter int NW  = 16
) (
    input  logic          clk,
    input  logic          ic_rst_n,
    input  logic          ic_start,
    input  logic          ic_stop,
    input  logic          ic_loop,
    input  logic [M-1:0]  id_p_start,
    input  logic [M-1:0]  id_p_step,
    input  logic [NW-1:0] id_n_samples,
    output logic [M-1:0]  od_p_ac,
    output logic          oc_en_ac,
    output logic          oc_val_data,
    output logic          oc_busy,
    output logic          oc_done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_r;
    logic [DW-1:0]  div_cnt_r;
    logic [NW-1:0]  smp_cnt_r;
    logic [M-1:0]   p_start_r;
    logic [M-1:0]   p_step_r;
    logic [NW-1:0]  n_r;
    logic           loop_r;
    logic [M-1:0]   p_ac_r;
    logic           en_r;
    logic           busy_r;
    logic           done_r;

    logic           div_wrap_s;
    logic [DW-1:0]  div_nxt_s;
    logic           last_smp_s;
    logic           start_ok_s;

    // Divider wrap detection, next divider value and sweep-position flags.
    always_comb begin
        div_wrap_s = (div_cnt_r == DIV_LAST);
        if (div_wrap_s) begin
            div_nxt_s = {DW{1'b0}};
        end else begin
            div_nxt_s = div_cnt_r + DW'(1);
        end
        last_smp_s = (smp_cnt_r == (n_r - NW'(1)));
        start_ok_s = ic_start && !ic_stop && (id_n_samples != {NW{1'b0}});
    end

    // Sweep FSM with counters, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= {DW{1'b0}};
            smp_cnt_r <= {NW{1'b0}};
            p_start_r <= {M{1'b0}};
            p_step_r  <= {M{1'b0}};
            n_r       <= {NW{1'b0}};
            loop_r    <= 1'b0;
            p_ac_r    <= {M{1'b0}};
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_ok_s) begin
                        // Configuration is frozen for the whole sweep.
                        state_r   <= ST_RUN;
                        p_start_r <= id_p_start;
                        p_step_r  <= id_p_step;
                        n_r       <= id_n_samples;
                        loop_r    <= ic_loop;
                        div_cnt_r <= {DW{1'b0}};
                        smp_cnt_r <= {NW{1'b0}};
                        p_ac_r    <= id_p_start;
                        en_r      <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        en_r   <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ic_stop) begin
                        state_r <= ST_IDLE;
                        en_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (!loop_r && (div_cnt_r == {DW{1'b0}}) && last_smp_s) begin
                        // This edge ends the strobe of the last sample.
                        // Checked before the wrap so DIV=1 terminates too.
                        state_r <= ST_IDLE;
                        en_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        div_cnt_r <= div_nxt_s;
                        en_r      <= div_wrap_s;
                        done_r    <= 1'b0;
                        if (div_wrap_s) begin
                            // Next strobe: advance the sample, or wrap a looped sweep.
                            if (last_smp_s) begin
                                smp_cnt_r <= {NW{1'b0}};
                                p_ac_r    <= p_start_r;
                            end else begin
                                smp_cnt_r <= smp_cnt_r + NW'(1);
                                p_ac_r    <= p_ac_r + p_step_r;
                            end
                        end else begin
                            smp_cnt_r <= smp_cnt_r;
                            p_ac_r    <= p_ac_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign od_p_ac     = p_ac_r;
    assign oc_en_ac    = en_r;
    assign oc_val_data = en_r;
    assign oc_busy     = busy_r;
    assign oc_done     = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Two instances share the same stimulus: one with DIV=4 and one with DIV=1.
//   The expected outputs come from the sweep rules expressed as arithmetic on
//   the time since the start edge. Let t be the cycle index after the start
//   edge, starting at 1. A strobe occurs when (t-1) mod DIV == 0, and it
//   carries p_start + ((t-1)/DIV mod n)*p_step. A single-shot sweep finishes
//   at t = (n-1)*DIV + 2. Directed literal checks pin the main cases.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ic_start;
    logic        ic_stop;
    logic        ic_loop;
    logic [23:0] id_p_start;
    logic [23:0] id_p_step;
    logic [15:0] id_n_samples;

    logic [1:0][23:0] d_p;
    logic [1:0]       d_en;
    logic [1:0]       d_val;
    logic [1:0]       d_busy;
    logic [1:0]       d_done;

    int errors = 0;
    int checks = 0;

    dds_sweep_ctrl #(.M(24), .DIV(4), .NW(16)) u_dut4 (
        .clk          (clk),
        .ic_rst_n     (rst_n),
        .ic_start     (ic_start),
        .ic_stop      (ic_stop),
        .ic_loop      (ic_loop),
        .id_p_start   (id_p_start),
        .id_p_step    (id_p_step),
        .id_n_samples (id_n_samples),
        .od_p_ac      (d_p[0]),
        .oc_en_ac     (d_en[0]),
        .oc_val_data  (d_val[0]),
        .oc_busy      (d_busy[0]),
        .oc_done      (d_done[0])
    );

    dds_sweep_ctrl #(.M(24), .DIV(1), .NW(16)) u_dut1 (
        .clk          (clk),
        .ic_rst_n     (rst_n),
        .ic_start     (ic_start),
        .ic_stop      (ic_stop),
        .ic_loop      (ic_loop),
        .id_p_start   (id_p_start),
        .id_p_step    (id_p_step),
        .id_n_samples (id_n_samples),
        .od_p_ac      (d_p[1]),
        .oc_en_ac     (d_en[1]),
        .oc_val_data  (d_val[1]),
        .oc_busy      (d_busy[1]),
        .oc_done      (d_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (one slot per instance) -------------
    logic        m_run  [2];
    longint      m_t    [2];
    longint      m_cs   [2];
    longint      m_cp   [2];
    longint      m_cn   [2];
    logic        m_cl   [2];
    logic [23:0] x_p    [2];
    logic        x_en   [2];
    logic        x_busy [2];
    logic        x_done [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_cs[i]   <= 0;
                m_cp[i]   <= 0;
                m_cn[i]   <= 0;
                m_cl[i]   <= 1'b0;
                x_p[i]    <= 24'h0;
                x_en[i]   <= 1'b0;
                x_busy[i] <= 1'b0;
                x_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin : unit
                automatic longint d    = (i == 0) ? 4 : 1;
                automatic logic   run  = m_run[i];
                automatic longint t    = m_t[i];
                automatic longint cs   = m_cs[i];
                automatic longint cp   = m_cp[i];
                automatic longint cn   = m_cn[i];
                automatic logic   cl   = m_cl[i];
                automatic longint p    = longint'(x_p[i]);
                automatic logic   en   = 1'b0;
                automatic logic   done = 1'b0;
                if (!run) begin
                    if (ic_start && !ic_stop && id_n_samples != 16'd0) begin
                        run = 1'b1;
                        t   = 1;
                        cs  = longint'(id_p_start);
                        cp  = longint'(id_p_step);
                        cn  = longint'(id_n_samples);
                        cl  = ic_loop;
                    end
                end else if (ic_stop) begin
                    run = 1'b0;
                end else begin
                    t = t + 1;
                end
                if (run) begin
                    if (!cl && t == (cn - 1) * d + 2) begin
                        run  = 1'b0;
                        done = 1'b1;
                    end else if ((t - 1) % d == 0) begin
                        en = 1'b1;
                        p  = (cs + (((t - 1) / d) % cn) * cp) & 64'hFF_FFFF;
                    end
                end
                m_run[i]  <= run;
                m_t[i]    <= t;
                m_cs[i]   <= cs;
                m_cp[i]   <= cp;
                m_cn[i]   <= cn;
                m_cl[i]   <= cl;
                x_p[i]    <= p[23:0];
                x_en[i]   <= en;
                x_busy[i] <= run;
                x_done[i] <= done;
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cmp%0d_p", i),    32'(d_p[i]),    32'(x_p[i]));
            chk($sformatf("cmp%0d_en", i),   32'(d_en[i]),   32'(x_en[i]));
            chk($sformatf("cmp%0d_val", i),  32'(d_val[i]),  32'(x_en[i]));
            chk($sformatf("cmp%0d_busy", i), 32'(d_busy[i]), 32'(x_busy[i]));
            chk($sformatf("cmp%0d_done", i), 32'(d_done[i]), 32'(x_done[i]));
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic start_sweep(input logic [23:0] ps, input logic [23:0] st,
                               input logic [15:0] n, input logic lp);
        id_p_start   = ps;
        id_p_step    = st;
        id_n_samples = n;
        ic_loop      = lp;
        ic_start     = 1'b1;
        @(posedge clk);
        #1;
        ic_start     = 1'b0;
        // Scramble the inputs to show the latched copy is used.
        id_p_start   = 24'hABCDEF;
        id_p_step    = 24'h123456;
        id_n_samples = 16'd7;
        ic_loop      = ~lp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        ic_stop = 1'b1;
        @(posedge clk);
        #1;
        ic_stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed tests ----------------------------------------
    initial begin
        rst_n        = 1'b0;
        ic_start     = 1'b0;
        ic_stop      = 1'b0;
        ic_loop      = 1'b0;
        id_p_start   = 24'h0;
        id_p_step    = 24'h0;
        id_n_samples = 16'd0;
        #13;
        chk("rst_p",    32'(d_p[0]),    32'h0);
        chk("rst_en",   32'(d_en[0]),   32'h0);
        chk("rst_busy", 32'(d_busy[0]), 32'h0);
        chk("rst_done", 32'(d_done[0]), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single shot, DIV=4: strobes at 1,5,9; done and busy fall at 10.
        start_sweep(24'h000100, 24'h000010, 16'd3, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    chk("ss_en1", 32'(d_en[0]), 32'h1);
                    chk("ss_p1",  32'(d_p[0]),  32'h000100);
                end
                2: chk("ss_en2", 32'(d_en[0]), 32'h0);
                5: begin
                    chk("ss_p5",       32'(d_p[0]), 32'h000110);
                    chk("ss_model_p5", 32'(x_p[0]), 32'h000110);
                end
                9: begin
                    chk("ss_p9",    32'(d_p[0]),    32'h000120);
                    chk("ss_busy9", 32'(d_busy[0]), 32'h1);
                end
                10: begin
                    chk("ss_done10",       32'(d_done[0]), 32'h1);
                    chk("ss_model_done10", 32'(x_done[0]), 32'h1);
                    chk("ss_busy10",       32'(d_busy[0]), 32'h0);
                    chk("ss_hold10",       32'(d_p[0]),    32'h000120);
                end
                11: chk("ss_done11", 32'(d_done[0]), 32'h0);
                default: ;
            endcase
        end
        go_idle();

        // Loop: the 4th strobe at cycle 13 carries p_start again; then stop.
        start_sweep(24'h000100, 24'h000010, 16'd3, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 13) begin
                chk("lp_en13",       32'(d_en[0]), 32'h1);
                chk("lp_p13",        32'(d_p[0]),  32'h000100);
                chk("lp_model_p13",  32'(x_p[0]),  32'h000100);
            end
        end
        ic_stop = 1'b1;
        @(posedge clk);
        #1;
        ic_stop = 1'b0;
        @(negedge clk);
        chk("stop_en",   32'(d_en[0]),   32'h0);
        chk("stop_busy", 32'(d_busy[0]), 32'h0);
        chk("stop_p",    32'(d_p[0]),    32'h000100);
        go_idle();

        // Wrap modulo 2^24.
        start_sweep(24'hFFFFF0, 24'h000020, 16'd2, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) chk("wr_p1", 32'(d_p[0]), 32'hFFFFF0);
            if (c == 5) chk("wr_p5", 32'(d_p[0]), 32'h000010);
            if (c == 2) chk("wr_dut1_p2", 32'(d_p[1]), 32'h000010);
        end
        go_idle();

        // n=0: start ignored.
        start_sweep(24'h000100, 24'h000010, 16'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("n0_busy", 32'(d_busy[0]), 32'h0);
            chk("n0_en",   32'(d_en[1]),   32'h0);
        end

        // start and stop together: stays idle.
        ic_stop = 1'b1;
        start_sweep(24'h000100, 24'h000010, 16'd3, 1'b0);
        ic_stop = 1'b0;
        @(negedge clk);
        chk("ss_stop_busy", 32'(d_busy[0]), 32'h0);
        chk("ss_stop_en",   32'(d_en[0]),   32'h0);
        repeat (2) @(negedge clk);

        // start pulses during RUN do not disturb the sequence.
        start_sweep(24'h000100, 24'h000010, 16'd3, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 3) begin
                id_p_start   = 24'h555555;
                id_n_samples = 16'd1;
                ic_start     = 1'b1;
            end else begin
                ic_start = 1'b0;
            end
            if (c == 5)  chk("rs_p5",    32'(d_p[0]),    32'h000110);
            if (c == 10) chk("rs_done",  32'(d_done[0]), 32'h1);
        end
        go_idle();

        // DIV=1, n=4: four back-to-back strobes with k*step, then done.
        start_sweep(24'h000000, 24'h000100, 16'd4, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("d1_en", 32'(d_en[1]), 32'h1);
                chk("d1_p",  32'(d_p[1]),  32'((c - 1) * 32'h100));
            end else begin
                chk("d1_done", 32'(d_done[1]), 32'h1);
                chk("d1_en5",  32'(d_en[1]),   32'h0);
            end
        end
        repeat (16) @(negedge clk);

        // Asynchronous reset mid-sweep while a strobe is high.
        start_sweep(24'h000100, 24'h000010, 16'd3, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_p",    32'(d_p[0]),    32'h0);
        chk("arst_en",   32'(d_en[0]),   32'h0);
        chk("arst_busy", 32'(d_busy[0]), 32'h0);
        chk("arst_en1",  32'(d_en[1]),   32'h0);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_idle", 32'(d_busy[0]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
